demux_scheduler: RTL and testbench

DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

---
 rtl/demux_sched_pkg.sv | 23 ++
 rtl/demux_scheduler_rr_arbiter_8.sv | 36 +++
 rtl/demux_scheduler.sv | 155 +++++++++++++++
 tb/tb_demux_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the demux scheduler: FSM states, channel
// count and default pulse/gap timing.
package demux_sched_pkg;

   localparam int NCH           = 8;
   localparam int IDXW          = 3;
   localparam int CNTW          = 8;
   localparam int DEF_PULSE_LEN = 4;
   localparam int DEF_GAP_LEN   = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRIVE = 2'd2,
      GAP   = 2'd3
   } state_t;

   // Round-robin pointer advances to the channel just after the winner.
   function automatic logic [IDXW-1:0] nextPtr(input logic [IDXW-1:0] idx);
      return idx + IDXW'(1);
   endfunction

endpackage

// File: rtl/demux_scheduler_rr_arbiter_8.sv
// Combinational 8-way round-robin arbiter: the search starts at i_ptr and
// wraps 7->0, returning the first requesting channel.
module rr_arbiter_8
   import demux_sched_pkg::*;
(
   input  logic [NCH-1:0]  i_req,
   input  logic [IDXW-1:0] i_ptr,
   output logic [NCH-1:0]  o_grant,
   output logic [IDXW-1:0] o_idx,
   output logic            o_valid
);

   logic [NCH-1:0]  w_rot;
   logic [IDXW-1:0] w_off;

   // Rotate so bit 0 is the pointer channel; the lowest set bit then wins.
   always_comb begin
      w_rot = '0;
      for (int k = 0; k < NCH; k++) begin
         w_rot[k] = i_req[i_ptr + IDXW'(k)];
      end
      w_off = '0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_off = IDXW'(k);
         end
      end
   end

   always_comb begin
      o_valid = |i_req;
      o_idx   = i_ptr + w_off;
      o_grant = o_valid ? (NCH'(1) << o_idx) : '0;
   end

endmodule

// File: rtl/demux_scheduler.sv
// Round-robin scheduler driving an 8-way demux: per grant it sets the address,
// pulses D for PULSE_LEN cycles, holds the address for GAP_LEN more, then ACKs.
module demux_scheduler
   import demux_sched_pkg::*;
#(
   parameter int PULSE_LEN = DEF_PULSE_LEN,
   parameter int GAP_LEN   = DEF_GAP_LEN
)
(
   input  logic           CLK,
   input  logic           RST_N,
   input  logic           EN,
   input  logic [NCH-1:0] REQ,
   output logic           A0,
   output logic           A1,
   output logic           A2,
   output logic           D,
   output logic [NCH-1:0] GNT,
   output logic [NCH-1:0] ACK,
   output logic           BUSY
);

   localparam logic [CNTW-1:0] L_PULSE = CNTW'(PULSE_LEN);
   localparam logic [CNTW-1:0] L_GAP   = CNTW'(GAP_LEN);

   state_t          r_state;
   logic [CNTW-1:0] r_cnt;
   logic [IDXW-1:0] r_ptr;
   logic [IDXW-1:0] r_addr;
   logic            r_d;
   logic [NCH-1:0]  r_gnt;
   logic [NCH-1:0]  r_ack;
   logic            r_busy;

   state_t          w_nextState;
   logic [CNTW-1:0] w_nextCnt;
   logic            w_take;
   logic [NCH-1:0]  w_winGrant;
   logic [IDXW-1:0] w_winIdx;
   logic            w_winValid;
   logic [IDXW-1:0] w_nextPtr;
   logic [IDXW-1:0] w_nextAddr;
   logic            w_nextD;
   logic [NCH-1:0]  w_nextGnt;
   logic [NCH-1:0]  w_nextAck;
   logic            w_nextBusy;

   rr_arbiter_8 u_arb (
      .i_req   (REQ),
      .i_ptr   (r_ptr),
      .o_grant (w_winGrant),
      .o_idx   (w_winIdx),
      .o_valid (w_winValid)
   );

   // All state and every output is a flop, so the async reset clears them at once.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_addr  <= '0;
         r_d     <= 1'b0;
         r_gnt   <= '0;
         r_ack   <= '0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         r_ptr   <= w_nextPtr;
         r_addr  <= w_nextAddr;
         r_d     <= w_nextD;
         r_gnt   <= w_nextGnt;
         r_ack   <= w_nextAck;
         r_busy  <= w_nextBusy;
      end
   end

   // The counter is loaded with each state's length on entry and leaves at 1.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_take      = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_nextCnt = '0;
            if (EN && w_winValid) begin
               w_take      = 1'b1;
               w_nextState = SETUP;
               w_nextCnt   = CNTW'(1);
            end
         end
         SETUP: begin
            w_nextState = DRIVE;
            w_nextCnt   = L_PULSE;
         end
         DRIVE: begin
            if (r_cnt == CNTW'(1)) begin
               if (GAP_LEN == 0) begin
                  w_nextState = IDLE;
                  w_nextCnt   = '0;
               end else begin
                  w_nextState = GAP;
                  w_nextCnt   = L_GAP;
               end
            end else begin
               w_nextCnt = r_cnt - CNTW'(1);
            end
         end
         GAP: begin
            if (r_cnt == CNTW'(1)) begin
               w_nextState = IDLE;
               w_nextCnt   = '0;
            end else begin
               w_nextCnt = r_cnt - CNTW'(1);
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end
      endcase
   end

   // Outputs are computed from the next state so the registers line up with it;
   // ACK is set when the next cycle is the final one before IDLE.
   always_comb begin
      w_nextPtr  = r_ptr;
      w_nextAddr = r_addr;
      w_nextGnt  = r_gnt;
      if (w_take) begin
         w_nextPtr  = nextPtr(w_winIdx);
         w_nextAddr = w_winIdx;
         w_nextGnt  = w_winGrant;
      end else if (w_nextState == IDLE) begin
         w_nextGnt = '0;
      end
      w_nextD    = (w_nextState == DRIVE);
      w_nextBusy = (w_nextState != IDLE);
      w_nextAck  = '0;
      if (w_nextCnt == CNTW'(1) &&
          ((w_nextState == GAP) || (w_nextState == DRIVE && GAP_LEN == 0))) begin
         w_nextAck = w_nextGnt;
      end
   end

   assign A0   = r_addr[2];
   assign A1   = r_addr[1];
   assign A2   = r_addr[0];
   assign D    = r_d;
   assign GNT  = r_gnt;
   assign ACK  = r_ack;
   assign BUSY = r_busy;

endmodule

// File: tb/tb_demux_scheduler.sv
// Bench for demux_scheduler: two instances (4/2 and 1/0 timing) share stimulus
// and are compared every cycle against a transaction-position reference model.
module tb_demux_scheduler;

   logic       CLK;
   logic       RST_N;
   logic       EN;
   logic [7:0] REQ;

   logic       d0A0, d0A1, d0A2, d0D, d0Busy;
   logic [7:0] d0Gnt, d0Ack;
   logic       d1A0, d1A1, d1A2, d1D, d1Busy;
   logic [7:0] d1Gnt, d1Ack;

   int cmpCount = 0;
   int errCount = 0;

   int mPos[2];
   int mPtr[2];
   int mCh[2];
   int mAddr[2];
   int mP[2] = '{4, 1};
   int mG[2] = '{2, 0};

   demux_scheduler #(.PULSE_LEN(4), .GAP_LEN(2)) dut (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .REQ(REQ),
      .A0(d0A0), .A1(d0A1), .A2(d0A2), .D(d0D),
      .GNT(d0Gnt), .ACK(d0Ack), .BUSY(d0Busy)
   );

   demux_scheduler #(.PULSE_LEN(1), .GAP_LEN(0)) dutShort (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .REQ(REQ),
      .A0(d1A0), .A1(d1A1), .A2(d1A2), .D(d1D),
      .GNT(d1Gnt), .ACK(d1Ack), .BUSY(d1Busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic cmp(input string tag, input string name, input int d,
                      input logic [7:0] obs, input logic [7:0] exp);
      cmpCount++;
      assert (obs === exp) else begin
         errCount++;
         $error("[TB] FAIL %s.%s dut%0d observed=%h expected=%h", tag, name, d, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         mPos[d]  = 0;
         mPtr[d]  = 0;
         mCh[d]   = 0;
         mAddr[d] = 0;
      end
   endtask

   // A transaction occupies positions 1..L: 1 setup, then pulse, then gap.
   task automatic modelStep();
      for (int d = 0; d < 2; d++) begin
         int len;
         bit found;
         len = 1 + mP[d] + mG[d];
         if (mPos[d] == 0) begin
            if (EN && REQ != 8'h00) begin
               found = 0;
               for (int k = 0; k < 8; k++) begin
                  int c;
                  c = (mPtr[d] + k) % 8;
                  if (!found && REQ[c]) begin
                     found  = 1;
                     mCh[d] = c;
                  end
               end
               mPtr[d]  = (mCh[d] + 1) % 8;
               mAddr[d] = mCh[d];
               mPos[d]  = 1;
            end
         end else if (mPos[d] == len) begin
            mPos[d] = 0;
         end else begin
            mPos[d]++;
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      for (int d = 0; d < 2; d++) begin
         int len, pos;
         logic [7:0] eGnt, eAck, oGnt, oAck;
         logic [2:0] oAddr;
         logic eD, eBusy, oD, oBusy;
         len   = 1 + mP[d] + mG[d];
         pos   = mPos[d];
         eBusy = (pos != 0);
         eD    = (pos >= 2) && (pos <= mP[d] + 1);
         eGnt  = (pos != 0) ? (8'h01 << mCh[d]) : 8'h00;
         eAck  = (pos == len) ? (8'h01 << mCh[d]) : 8'h00;
         oAddr = (d == 0) ? {d0A0, d0A1, d0A2} : {d1A0, d1A1, d1A2};
         oD    = (d == 0) ? d0D : d1D;
         oBusy = (d == 0) ? d0Busy : d1Busy;
         oGnt  = (d == 0) ? d0Gnt : d1Gnt;
         oAck  = (d == 0) ? d0Ack : d1Ack;
         cmp(tag, "addr", d, {5'd0, oAddr}, 8'(mAddr[d]));
         cmp(tag, "D",    d, {7'd0, oD},    {7'd0, eD});
         cmp(tag, "BUSY", d, {7'd0, oBusy}, {7'd0, eBusy});
         cmp(tag, "GNT",  d, oGnt, eGnt);
         cmp(tag, "ACK",  d, oAck, eAck);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic [7:0] req);
      EN  = en;
      REQ = req;
      @(posedge CLK);
      modelStep();
      #1;
   endtask

   task automatic runCycle(input logic en, input logic [7:0] req, input string tag);
      applyStimulus(en, req);
      checkOutput(tag);
   endtask

   // Entered and left one time unit after a rising edge; reset lands mid-cycle.
   task automatic pulseReset(input string tag);
      #1;
      RST_N = 1'b0;
      modelReset();
      #1;
      checkOutput(tag);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      checkOutput(tag);
   endtask

   initial begin
      RST_N = 1'b0;
      EN    = 1'b0;
      REQ   = 8'h00;
      modelReset();
      #3;
      checkOutput("reset");
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      checkOutput("afterReset");

      runCycle(1'b1, 8'h20, "single20");
      cmp("single20", "addrConst", 0, {5'd0, d0A0, d0A1, d0A2}, 8'h05);
      cmp("single20", "gntConst",  0, d0Gnt, 8'h20);
      for (int i = 0; i < 10; i++) runCycle(1'b1, 8'h00, "single20");

      pulseReset("rst1");
      for (int i = 0; i < 66; i++) runCycle(1'b1, 8'hFF, "allReq");

      pulseReset("rst2");
      runCycle(1'b1, 8'h04, "ptrTo3");
      for (int i = 0; i < 8; i++) runCycle(1'b1, 8'h00, "ptrTo3");
      runCycle(1'b1, 8'h05, "wrap");
      cmp("wrap", "gntConst", 0, d0Gnt, 8'h01);
      for (int i = 0; i < 20; i++) runCycle(1'b1, 8'h05, "wrap");

      pulseReset("rst3");
      runCycle(1'b1, 8'h40, "ch6");
      runCycle(1'b1, 8'h00, "ch6");
      runCycle(1'b1, 8'h00, "ch6");
      pulseReset("midDrive");
      cmp("midDrive", "dConst", 0, {7'd0, d0D}, 8'h00);
      runCycle(1'b1, 8'h40, "ch6again");
      for (int i = 0; i < 10; i++) runCycle(1'b1, 8'h00, "ch6again");

      pulseReset("rst4");
      runCycle(1'b1, 8'h01, "short");
      cmp("short", "gntConst", 1, d1Gnt, 8'h01);
      runCycle(1'b1, 8'h00, "short");
      cmp("short", "ackConst", 1, d1Ack, 8'h01);
      cmp("short", "dConst",   1, {7'd0, d1D}, 8'h01);
      runCycle(1'b1, 8'h00, "short");
      cmp("short", "busyConst", 1, {7'd0, d1Busy}, 8'h00);

      pulseReset("rst5");
      runCycle(1'b1, 8'h0F, "enDrop");
      for (int i = 0; i < 15; i++) runCycle(1'b0, 8'h0F, "enDrop");
      cmp("enDrop", "busyConst", 0, {7'd0, d0Busy}, 8'h00);
      for (int i = 0; i < 10; i++) runCycle(1'b1, 8'h0F, "enBack");

      for (int i = 0; i < 400; i++) begin
         logic en;
         logic [7:0] req;
         en  = ($urandom_range(0, 9) != 0);
         req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            pulseReset("randRst");
         end
         runCycle(en, req, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule
